// File: rtl/pudding_pkg.sv
// Shared types and sizing for the PUDDING DAC loader.
// Default chain length and code width for the 128-source array.
package pudding_pkg;

  localparam int PUDDING_NBITS  = 128;
  localparam int PUDDING_CODE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    XFER,
    RB_XFER,
    RB_SHIFT,
    DONE
  } loader_state_t;

endpackage

// File: rtl/pudding_dac_loader_if.sv
// Host-side code handshake for the PUDDING DAC loader.
// The host drives the code and its valid flag; the loader returns ready.
interface pudding_dac_loader_if #(
  parameter int CODE_W = 8
);

  logic [CODE_W-1:0] code_i;
  logic              code_valid;
  logic              code_ready;

  modport master (output code_i, output code_valid, input code_ready);
  modport slave  (input code_i, input code_valid, output code_ready);

endinterface

// File: rtl/pudding_shift_pacer.sv
// Paces chain shift strobes: one strobe every SHIFT_DIV clocks, NBITS strobes per run.
// A start pulse arms a run beginning on the following cycle; clear wins over start.
module pudding_shift_pacer #(
  parameter int NBITS     = 128,
  parameter int SHIFT_DIV = 1,
  parameter int IDX_W     = $clog2(NBITS)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  output logic             strobe,
  output logic [IDX_W-1:0] index,
  output logic             last
);

  localparam int DIV_W = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;

  logic             run_q, run_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    strobe = run_q && (cnt_q == DIV_W'(SHIFT_DIV - 1));
    last   = strobe && (idx_q == IDX_W'(NBITS - 1));
    run_d  = run_q;
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    if (start) begin
      run_d = 1'b1;
      cnt_d = '0;
      idx_d = '0;
    end else if (run_q) begin
      if (strobe) begin
        cnt_d = '0;
        idx_d = idx_q + IDX_W'(1);
        if (last) begin
          run_d = 1'b0;
          idx_d = '0;
        end
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign index = idx_q;

endmodule

// File: rtl/pudding_dac_loader.sv
// Loads a thermometer-coded code into the PUDDING DAC daisy chain and latches it.
// Optional serial readback check is built when PUDDING_READBACK_EN is defined.
//
// state    | meaning
// IDLE     | ready for a code
// SHIFT    | clocking the thermometer pattern into the chain, MSB end first
// XFER     | one-cycle transfer strobe, chain -> state
// RB_XFER  | one-cycle transfer strobe, state -> chain (readback build only)
// RB_SHIFT | shifting the chain out and comparing with what was sent
// DONE     | one-cycle done pulse
module pudding_dac_loader
  import pudding_pkg::*;
#(
  parameter int NBITS     = PUDDING_NBITS,
  parameter int CODE_W    = PUDDING_CODE_W,
  parameter int SHIFT_DIV = 1
) (
  input  logic                clk,
  input  logic                rst,
  pudding_dac_loader_if.slave bus,
  input  logic                dac_en_i,
  output logic                datum_o,
  output logic                shift_o,
  output logic                transfer_o,
  output logic                dir_o,
  output logic                dac_en_o,
  input  logic                chain_so_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                mismatch_o
);

  localparam int IDX_W = $clog2(NBITS);

  loader_state_t     state_q, state_d;
  logic [CODE_W-1:0] k_q, k_d;
  logic              dac_en_q, dac_en_d;
  logic              pace_start;
  logic              strobe;
  logic              last;
  logic [IDX_W-1:0]  idx;
  logic              sent_bit;
  logic [CODE_W-1:0] k_sat;

  pudding_shift_pacer #(
    .NBITS     (NBITS),
    .SHIFT_DIV (SHIFT_DIV),
    .IDX_W     (IDX_W)
  ) u_pacer (
    .clk    (clk),
    .clear  (rst),
    .start  (pace_start),
    .strobe (strobe),
    .index  (idx),
    .last   (last)
  );

  // Bit j of the serial stream is 1 once the leading NBITS-K zeros are out.
  assign sent_bit = CODE_W'(idx) >= (CODE_W'(NBITS) - k_q);
  assign k_sat    = (bus.code_i > CODE_W'(NBITS)) ? CODE_W'(NBITS) : bus.code_i;
  assign dac_en_d = dac_en_i;

`ifdef PUDDING_READBACK_EN
  logic mismatch_q, mismatch_d;
`endif

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    pace_start = 1'b0;
    datum_o    = 1'b0;
    shift_o    = 1'b0;
    transfer_o = 1'b0;
    dir_o      = 1'b0;
    done_o     = 1'b0;
`ifdef PUDDING_READBACK_EN
    mismatch_d = mismatch_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.code_valid && !rst) begin
          k_d        = k_sat;
          pace_start = 1'b1;
          state_d    = SHIFT;
`ifdef PUDDING_READBACK_EN
          mismatch_d = 1'b0;
`endif
        end
      end
      SHIFT: begin
        datum_o = sent_bit;
        shift_o = strobe;
        if (last) state_d = XFER;
      end
      XFER: begin
        transfer_o = 1'b1;
        dir_o      = 1'b1;
`ifdef PUDDING_READBACK_EN
        state_d    = RB_XFER;
`else
        state_d    = DONE;
`endif
      end
`ifdef PUDDING_READBACK_EN
      RB_XFER: begin
        transfer_o = 1'b1;
        pace_start = 1'b1;
        state_d    = RB_SHIFT;
      end
      RB_SHIFT: begin
        shift_o = strobe;
        if (strobe && (chain_so_i != sent_bit)) mismatch_d = 1'b1;
        if (last) state_d = DONE;
      end
`endif
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset silences the DAC-side strobes in the same cycle it is applied.
    if (rst) begin
      pace_start = 1'b0;
      datum_o    = 1'b0;
      shift_o    = 1'b0;
      transfer_o = 1'b0;
      dir_o      = 1'b0;
      done_o     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      dac_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      dac_en_q <= dac_en_d;
    end
  end

`ifdef PUDDING_READBACK_EN
  always_ff @(posedge clk) begin
    if (rst) mismatch_q <= 1'b0;
    else     mismatch_q <= mismatch_d;
  end
  assign mismatch_o = mismatch_q && !rst;
`else
  logic unused_chain_so;
  assign unused_chain_so = chain_so_i;
  assign mismatch_o      = 1'b0;
`endif

  assign bus.code_ready = (state_q == IDLE) && !rst;
  assign busy_o         = (state_q != IDLE) && !rst;
  assign dac_en_o       = dac_en_q && !rst;

endmodule

// File: tb/tb_pudding_dac_loader.sv
// Directed bench for pudding_dac_loader with a behavioural 128-bit chain/state register model.
// Instance a runs SHIFT_DIV=1, instance b runs SHIFT_DIV=3.
module tb_pudding_dac_loader;
  import pudding_pkg::*;

  localparam int NB    = PUDDING_NBITS;
  localparam int CW    = PUDDING_CODE_W;
  localparam int DIV_A = 1;
  localparam int DIV_B = 3;
`ifdef PUDDING_READBACK_EN
  localparam int RB_ON = 1;
`else
  localparam int RB_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pudding_dac_loader_if #(.CODE_W(CW)) bus_a ();
  pudding_dac_loader_if #(.CODE_W(CW)) bus_b ();

  logic [1:0] dac_en_i, datum_s, shift_s, xfer_s, dir_s, dac_en_o, so_s, busy_s, done_s, mm_s;

  logic [NB-1:0] chain_m [2] = '{{4{32'hA5C3_0F96}}, {4{32'h5A3C_F069}}};
  logic [NB-1:0] state_m [2] = '{{4{32'hA5C3_0F96}}, {4{32'h5A3C_F069}}};
  logic [NB-1:0] flip_m  [2];

  pudding_dac_loader #(.NBITS(NB), .CODE_W(CW), .SHIFT_DIV(DIV_A)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave), .dac_en_i(dac_en_i[0]),
    .datum_o(datum_s[0]), .shift_o(shift_s[0]), .transfer_o(xfer_s[0]), .dir_o(dir_s[0]),
    .dac_en_o(dac_en_o[0]), .chain_so_i(so_s[0]), .busy_o(busy_s[0]), .done_o(done_s[0]),
    .mismatch_o(mm_s[0])
  );

  pudding_dac_loader #(.NBITS(NB), .CODE_W(CW), .SHIFT_DIV(DIV_B)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave), .dac_en_i(dac_en_i[1]),
    .datum_o(datum_s[1]), .shift_o(shift_s[1]), .transfer_o(xfer_s[1]), .dir_o(dir_s[1]),
    .dac_en_o(dac_en_o[1]), .chain_so_i(so_s[1]), .busy_o(busy_s[1]), .done_o(done_s[1]),
    .mismatch_o(mm_s[1])
  );

  assign so_s[0] = chain_m[0][NB-1];
  assign so_s[1] = chain_m[1][NB-1];

  // Chain shifts left with datum into bit 0; transfer moves chain<->state by dir.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (shift_s[u]) chain_m[u] <= {chain_m[u][NB-2:0], datum_s[u]};
      if (xfer_s[u] && dir_s[u]) state_m[u] <= chain_m[u];
      if (xfer_s[u] && !dir_s[u]) chain_m[u] <= state_m[u] ^ flip_m[u];
    end
  end

  function automatic logic rdy(int u);
    return (u == 0) ? bus_a.code_ready : bus_b.code_ready;
  endfunction

  function automatic logic vld(int u);
    return (u == 0) ? bus_a.code_valid : bus_b.code_valid;
  endfunction

  int acc_cyc [2], n_acc [2], n_fwd [2], fwd_ones [2], first_fwd [2], last_fwd [2], gap_err [2];
  int n_rb [2], rb_ones [2], n_xf [2], xf_cyc [2], n_rbx [2], done_cyc [2], excl_err [2], dir_err [2];
  bit xf_seen [2];

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (shift_s[u] && xfer_s[u]) excl_err[u]++;
      if (dir_s[u] && !xfer_s[u]) dir_err[u]++;
      if (shift_s[u]) begin
        if (!xf_seen[u]) begin
          if (n_fwd[u] == 0) first_fwd[u] = cyc;
          else if (cyc - last_fwd[u] != ((u == 0) ? DIV_A : DIV_B)) gap_err[u]++;
          last_fwd[u] = cyc;
          n_fwd[u]++;
          if (datum_s[u]) fwd_ones[u]++;
        end else begin
          n_rb[u]++;
          if (datum_s[u]) rb_ones[u]++;
        end
      end
      if (xfer_s[u] && dir_s[u]) begin
        n_xf[u]++;
        xf_cyc[u]  = cyc;
        xf_seen[u] = 1'b1;
      end
      if (xfer_s[u] && !dir_s[u]) n_rbx[u]++;
      if (done_s[u]) done_cyc[u] = cyc;
      if (rdy(u) && vld(u)) begin
        acc_cyc[u]  = cyc + 1;
        n_acc[u]++;
        n_fwd[u]    = 0;
        fwd_ones[u] = 0;
        gap_err[u]  = 0;
        n_rb[u]     = 0;
        rb_ones[u]  = 0;
        n_xf[u]     = 0;
        n_rbx[u]    = 0;
        xf_seen[u]  = 1'b0;
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(string tag, logic [NB-1:0] obs, logic [NB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [NB-1:0] therm(int k);
    logic [NB-1:0] v;
    v = '0;
    for (int i = 0; i < NB; i++) v[i] = (i < k);
    return v;
  endfunction

  task automatic drive(int u, int code, logic v);
    if (u == 0) begin
      bus_a.code_i     = CW'(code);
      bus_a.code_valid = v;
    end else begin
      bus_b.code_i     = CW'(code);
      bus_b.code_valid = v;
    end
  endtask

  task automatic send(int u, int code);
    @(posedge clk); #1;
    drive(u, code, 1'b1);
    @(negedge clk);
    chk("ready_at_send", int'(rdy(u)), 1);
    @(posedge clk); #1;
    drive(u, 0, 1'b0);
  endtask

  task automatic wait_done(int u, int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_s[u]) begin
        got = 1'b1;
        break;
      end
    end
    #1;
    chk("done_seen", int'(got), 1);
  endtask

  task automatic finish_run(int u, int kexp, int exp_mm, int t0);
    int div;
    div = (u == 0) ? DIV_A : DIV_B;
    wait_done(u, 2 * NB * div + 20);
    chk("fwd_shifts", n_fwd[u], NB);
    chk("fwd_ones", fwd_ones[u], kexp);
    chk("first_shift", first_fwd[u] - t0, div - 1);
    chk("shift_gap_err", gap_err[u], 0);
    chk("xfer_latency", xf_cyc[u] - t0, NB * div);
    chk("done_latency", done_cyc[u] - t0, NB * div + 1 + RB_ON * (1 + NB * div));
    chk("xfer_count", n_xf[u], 1);
    chk("mismatch", int'(mm_s[u]), exp_mm);
    chk_vec("dac_state", state_m[u], therm(kexp));
`ifdef PUDDING_READBACK_EN
    chk("rb_shifts", n_rb[u], NB);
    chk("rb_ones", rb_ones[u], 0);
    chk("rb_xfer_count", n_rbx[u], 1);
`endif
    chk("shift_xfer_overlap", excl_err[u], 0);
    chk("dir_outside_xfer", dir_err[u], 0);
    @(negedge clk);
    chk("busy_after_done", int'(busy_s[u]), 0);
    chk("ready_after_done", int'(rdy(u)), 1);
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int acc0;
    int rdy_bad;
    bit got;
    flip_m[0] = '0;
    flip_m[1] = '0;
    dac_en_i  = 2'b00;
    drive(0, 0, 1'b0);
    drive(1, 0, 1'b0);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++)
      chk("outputs_in_reset", int'({shift_s[u], xfer_s[u], dir_s[u], datum_s[u], done_s[u],
                                    busy_s[u], mm_s[u], dac_en_o[u], rdy(u)}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", int'(rdy(0)), 1);
    chk("busy_after_reset", int'(busy_s[0]), 0);

    @(posedge clk); #1;
    dac_en_i[0] = 1'b1;
    @(negedge clk);
    chk("dac_en_before_edge", int'(dac_en_o[0]), 0);
    @(negedge clk);
    chk("dac_en_after_edge", int'(dac_en_o[0]), 1);

    send(0, 0);    t0 = acc_cyc[0]; finish_run(0, 0, 0, t0);
    send(0, 200);  t0 = acc_cyc[0]; finish_run(0, 128, 0, t0);
    send(0, 37);   t0 = acc_cyc[0]; finish_run(0, 37, 0, t0);
    send(0, 128);  t0 = acc_cyc[0]; finish_run(0, 128, 0, t0);
    send(1, 5);    t0 = acc_cyc[1]; finish_run(1, 5, 0, t0);
    chk_vec("b_state_low_bits", state_m[1], {{(NB-8){1'b0}}, 8'h1F});

    // Code 9 offered mid-sequence must be dropped.
    acc0    = n_acc[0];
    rdy_bad = 0;
    send(0, 3);
    t0 = acc_cyc[0];
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (i == 10) drive(0, 9, 1'b1);
      if (i == 30) drive(0, 9, 1'b0);
      @(negedge clk);
      if (rdy(0)) rdy_bad++;
    end
    chk("ready_while_busy", rdy_bad, 0);
    finish_run(0, 3, 0, t0);
    chk("accept_count", n_acc[0] - acc0, 1);

    // Reset after the 60th strobe abandons the load without any transfer.
    send(0, 100);
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (n_fwd[0] >= 60) begin
        got = 1'b1;
        break;
      end
    end
    chk("reached_shift60", int'(got), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("outputs_mid_reset", int'({shift_s[0], xfer_s[0], dir_s[0], datum_s[0], done_s[0],
                                   busy_s[0], mm_s[0], dac_en_o[0], rdy(0)}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("busy_after_abort", int'(busy_s[0]), 0);
    chk("ready_after_abort", int'(rdy(0)), 1);
    repeat (2 * NB) @(negedge clk);
    #1;
    chk("xfer_after_abort", n_xf[0], 0);
    chk("shifts_after_abort", n_fwd[0], 60);
    chk_vec("state_kept", state_m[0], therm(3));
    chk("dac_en_restored", int'(dac_en_o[0]), 1);

`ifdef PUDDING_READBACK_EN
    flip_m[0][100] = 1'b1;
    send(0, 77);   t0 = acc_cyc[0]; finish_run(0, 77, 1, t0);
    flip_m[0] = '0;
    send(0, 77);
    t0 = acc_cyc[0];
    chk("mismatch_cleared", int'(mm_s[0]), 0);
    finish_run(0, 77, 0, t0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
